pwm_ramp_ctrl: RTL and testbench

Soft-start and reversal sequencer for the motor PWM path. Takes a requested 7-bit duty and direction, then slews the commanded duty toward the request at a programmed rate, one step per N PWM periods. On a direction change it ramps the duty to zero, holds a dead time, flips DIR and ramps back up. DUTY drives the CCR input of the PWM block in place of the raw switches; PERIOD_TICK comes from the TCR period pulse (E).

---
 rtl/pwm_ramp_ctrl.sv | 155 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / reversal sequencer: slews DUTY toward the requested duty one step
// per RAMP_DIV PWM periods, and inserts a zero-duty dead time around DIR changes.
module pwm_ramp_ctrl #(
  parameter int unsigned WIDTH        = 7,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RAMP_DIV     = 4,
  parameter int unsigned DEAD_PERIODS = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             DIR_REQ,
  input  logic             PERIOD_TICK,
  output logic [WIDTH-1:0] DUTY,
  output logic             DIR,
  output logic             BUSY,
  output logic             AT_TARGET
);

  localparam int unsigned DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W = $clog2(DEAD_PERIODS + 1);

  localparam logic [WIDTH:0]    STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    DEAD     = 2'd3
  } state_t;

  state_t            state_q, state_nxt;
  logic [WIDTH-1:0]  duty_q, duty_nxt;
  logic              dir_q, dir_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;

  logic              ramping;
  logic              step_fire;
  logic [WIDTH-1:0]  eff_tgt;
  logic [WIDTH-1:0]  step_val;
  logic [WIDTH:0]    sum_x;
  logic [WIDTH:0]    diff_x;
  logic [WIDTH:0]    tgt_x;
  logic              underflow;

  // Saturating one-step move of DUTY toward eff_tgt, done one bit wider than DUTY
  always_comb begin
    ramping   = (state_q == RUN) || (state_q == STOPPING);
    eff_tgt   = ((state_q == RUN) && EN) ? TARGET : '0;
    step_fire = ramping && PERIOD_TICK && (div_cnt == DIV_LAST);
    tgt_x     = {1'b0, eff_tgt};
    sum_x     = {1'b0, duty_q} + STEP_X;
    diff_x    = {1'b0, duty_q} - STEP_X;
    underflow = ({1'b0, duty_q} < STEP_X);
    step_val  = duty_q;
    if (duty_q < eff_tgt) begin
      step_val = (sum_x > tgt_x) ? eff_tgt : sum_x[WIDTH-1:0];
    end else if (duty_q > eff_tgt) begin
      step_val = (underflow || (diff_x < tgt_x)) ? eff_tgt : diff_x[WIDTH-1:0];
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_nxt = state_q;
    duty_nxt  = duty_q;
    dir_nxt   = dir_q;
    div_nxt   = div_cnt;
    dead_nxt  = dead_cnt;

    if (ramping && PERIOD_TICK) begin
      div_nxt = step_fire ? '0 : div_cnt + DIV_W'(1);
    end
    if (step_fire) begin
      duty_nxt = step_val;
    end

    case (state_q)
      IDLE: begin
        duty_nxt = '0;
        div_nxt  = '0;
        if (DIR_REQ != dir_q) begin
          state_nxt = DEAD;
          dead_nxt  = '0;
        end else if (EN) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if ((DIR_REQ != dir_q) && (duty_q == '0)) begin
          state_nxt = DEAD;
          dead_nxt  = '0;
          div_nxt   = '0;
        end else if (DIR_REQ != dir_q) begin
          state_nxt = STOPPING;
        end else if (!EN && (duty_q == '0)) begin
          state_nxt = IDLE;
          div_nxt   = '0;
        end
      end
      STOPPING: begin
        if (DIR_REQ == dir_q) begin
          state_nxt = RUN;
        end else if (duty_q == '0) begin
          state_nxt = DEAD;
          dead_nxt  = '0;
          div_nxt   = '0;
        end
      end
      DEAD: begin
        duty_nxt = '0;
        div_nxt  = '0;
        if (dead_cnt == DEAD_LAST) begin
          dir_nxt   = DIR_REQ;
          dead_nxt  = '0;
          state_nxt = EN ? RUN : IDLE;
        end else if (PERIOD_TICK) begin
          dead_nxt = dead_cnt + DEAD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        duty_nxt  = '0;
        div_nxt   = '0;
        dead_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      dir_q    <= 1'b0;
      div_cnt  <= '0;
      dead_cnt <= '0;
    end else begin
      state_q  <= state_nxt;
      duty_q   <= duty_nxt;
      dir_q    <= dir_nxt;
      div_cnt  <= div_nxt;
      dead_cnt <= dead_nxt;
    end
  end

  assign DUTY      = duty_q;
  assign DIR       = dir_q;
  assign BUSY      = (state_q == STOPPING) || (state_q == DEAD);
  assign AT_TARGET = (state_q == RUN) && EN && (duty_q == TARGET);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: default instance for ramp/reversal/reset,
// plus a STEP=4, RAMP_DIV=1 instance for saturation at both ends.
module tb_pwm_ramp_ctrl;

  localparam int unsigned W        = 7;
  localparam int unsigned TICK_GAP = 8;

  logic         clk;
  logic         rst_n;

  logic         en, dir_req, tick;
  logic [W-1:0] target;
  logic [W-1:0] duty;
  logic         dir, busy, at_tgt;

  logic         en2, dir_req2, tick2;
  logic [W-1:0] target2;
  logic [W-1:0] duty2;
  logic         dir2, busy2, at_tgt2;

  int checks = 0;
  int errors = 0;

  pwm_ramp_ctrl #(.WIDTH(W), .STEP(1), .RAMP_DIV(4), .DEAD_PERIODS(16)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .TARGET(target), .DIR_REQ(dir_req),
    .PERIOD_TICK(tick), .DUTY(duty), .DIR(dir), .BUSY(busy), .AT_TARGET(at_tgt)
  );

  pwm_ramp_ctrl #(.WIDTH(W), .STEP(4), .RAMP_DIV(1), .DEAD_PERIODS(16)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .EN(en2), .TARGET(target2), .DIR_REQ(dir_req2),
    .PERIOD_TICK(tick2), .DUTY(duty2), .DIR(dir2), .BUSY(busy2), .AT_TARGET(at_tgt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n PWM periods; sel=0 drives the default instance, sel=1 the saturation one
  task automatic ticks(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) tick2 = 1'b1; else tick = 1'b1;
      @(negedge clk);
      tick  = 1'b0;
      tick2 = 1'b0;
      repeat (TICK_GAP - 2) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; dir_req = 1'b0; tick = 1'b0; target = '0;
    en2 = 1'b0; dir_req2 = 1'b0; tick2 = 1'b0; target2 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_duty", 32'(duty), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_at", 32'(at_tgt), 0);

    // Scenario 1: soft start to 10
    en = 1'b1; target = 7'd10;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ticks(3, 0);  chk("s1_duty_t3", 32'(duty), 0);
    ticks(1, 0);  chk("s1_duty_t4", 32'(duty), 1);
    chk("s1_at_ramp", 32'(at_tgt), 0);
    ticks(36, 0); chk("s1_duty_t40", 32'(duty), 10);
    chk("s1_at", 32'(at_tgt), 1);
    ticks(8, 0);  chk("s1_hold", 32'(duty), 10);

    // Scenario 2: ramp down to 3
    target = 7'd3;
    ticks(3, 0);  chk("s2_duty_t3", 32'(duty), 10);
    chk("s2_at_ramp", 32'(at_tgt), 0);
    ticks(1, 0);  chk("s2_duty_t4", 32'(duty), 9);
    ticks(24, 0); chk("s2_duty_t28", 32'(duty), 3);
    chk("s2_at", 32'(at_tgt), 1);

    // Scenario 4: reversal from 8
    target = 7'd8;
    ticks(20, 0); chk("s4_pre_duty", 32'(duty), 8);
    dir_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("s4_busy_stop", 32'(busy), 1);
    chk("s4_at_stop", 32'(at_tgt), 0);
    ticks(31, 0); chk("s4_duty_t31", 32'(duty), 1);
    ticks(1, 0);  chk("s4_duty_t32", 32'(duty), 0);
    chk("s4_dir_stop", 32'(dir), 0);
    ticks(15, 0); chk("s4_dead_dir", 32'(dir), 0);
    chk("s4_dead_busy", 32'(busy), 1);
    chk("s4_dead_duty", 32'(duty), 0);
    ticks(1, 0);  chk("s4_exit_dir", 32'(dir), 1);
    chk("s4_exit_busy", 32'(busy), 0);
    ticks(4, 0);  chk("s4_up_t4", 32'(duty), 1);
    ticks(28, 0); chk("s4_up_t32", 32'(duty), 8);
    chk("s4_at", 32'(at_tgt), 1);

    // Scenario 5: EN drop to idle, then restart to 2
    target = 7'd5;
    ticks(12, 0); chk("s5_pre_duty", 32'(duty), 5);
    en = 1'b0;
    @(negedge clk);
    chk("s5_at_en0", 32'(at_tgt), 0);
    ticks(19, 0); chk("s5_duty_t19", 32'(duty), 1);
    ticks(1, 0);  chk("s5_duty_t20", 32'(duty), 0);
    chk("s5_idle_busy", 32'(busy), 0);
    chk("s5_idle_at", 32'(at_tgt), 0);
    target = 7'd2; en = 1'b1;
    ticks(7, 0);  chk("s5_duty_t7", 32'(duty), 1);
    ticks(1, 0);  chk("s5_duty_t8", 32'(duty), 2);
    chk("s5_at", 32'(at_tgt), 1);

    // Scenario 6a: async reset in the middle of DEAD (DIR=1 before reset)
    dir_req = 1'b0;
    ticks(8, 0);  chk("s6_stop_duty", 32'(duty), 0);
    ticks(4, 0);  chk("s6_dead_busy", 32'(busy), 1);
    chk("s6_dead_dir", 32'(dir), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s6a_duty", 32'(duty), 0);
    chk("s6a_dir", 32'(dir), 0);
    chk("s6a_busy", 32'(busy), 0);

    // Scenario 6b: async reset mid-ramp at DUTY=6, DIR=1
    dir_req = 1'b1; target = 7'd6;
    @(negedge clk);
    rst_n = 1'b1;
    ticks(16, 0); chk("s6b_dir", 32'(dir), 1);
    ticks(24, 0); chk("s6b_duty", 32'(duty), 6);
    target = 7'd9;
    ticks(4, 0);  chk("s6b_ramp", 32'(duty), 7);
    rst_n = 1'b0;
    #1;
    chk("s6b_rst_duty", 32'(duty), 0);
    chk("s6b_rst_dir", 32'(dir), 0);
    chk("s6b_rst_busy", 32'(busy), 0);
    chk("s6b_rst_at", 32'(at_tgt), 0);

    // Recovery matches scenario 1
    dir_req = 1'b0; target = 7'd10;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ticks(3, 0);  chk("rec_duty_t3", 32'(duty), 0);
    ticks(1, 0);  chk("rec_duty_t4", 32'(duty), 1);
    ticks(36, 0); chk("rec_duty_t40", 32'(duty), 10);
    chk("rec_at", 32'(at_tgt), 1);

    // Scenario 3: saturation with STEP=4, one step per period
    en2 = 1'b1; target2 = 7'd125;
    ticks(1, 1);  chk("s3_first", 32'(duty2), 4);
    ticks(39, 1); chk("s3_125", 32'(duty2), 125);
    chk("s3_at125", 32'(at_tgt2), 1);
    target2 = 7'd127;
    ticks(1, 1);  chk("s3_sat_hi", 32'(duty2), 127);
    target2 = 7'd2;
    ticks(31, 1); chk("s3_down3", 32'(duty2), 3);
    ticks(1, 1);  chk("s3_down2", 32'(duty2), 2);
    target2 = 7'd0;
    ticks(1, 1);  chk("s3_sat_lo", 32'(duty2), 0);
    ticks(2, 1);  chk("s3_hold0", 32'(duty2), 0);
    chk("s3_dir", 32'(dir2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
